// File: rtl/act_stream.sv
// Two-stage elastic activation pipeline: per-lane pass/ReLU/leaky/ReLU6 on DIM lanes.
// Optional zero-lane counter compiled only when ACT_STREAM_ZERO_COUNT_EN is defined.
module act_stream #(
  parameter int unsigned DIM        = 4,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FRAC       = 8,
  parameter int unsigned LEAK_SHIFT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIM*WIDTH-1:0] in_vec,
  input  logic [1:0]           in_mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DIM*WIDTH-1:0] out_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          zero_cnt,
  input  logic                 cnt_clr
);

  localparam int unsigned VW = DIM * WIDTH;
  localparam longint unsigned SIX_Q   = 64'd6 << FRAC;
  localparam longint unsigned POS_MAX = (64'd1 << (WIDTH - 1)) - 64'd1;
  localparam logic [WIDTH-1:0] CLAMP  = WIDTH'((SIX_Q < POS_MAX) ? SIX_Q : POS_MAX);

  // Single-lane activation; the sign bit alone decides negativity, so the
  // most negative value is handled like any other negative input.
  function automatic logic [WIDTH-1:0] act_lane(input logic [WIDTH-1:0] x,
                                                input logic [1:0]       mode);
    logic [WIDTH-1:0] res;
    logic             neg;
    neg = x[WIDTH-1];
    res = x;
    case (mode)
      2'd0: res = x;
      2'd1: res = neg ? '0 : x;
      2'd2: res = neg ? WIDTH'($signed(x) >>> LEAK_SHIFT) : x;
      default: begin
        if (neg)            res = '0;
        else if (x > CLAMP) res = CLAMP;
        else                res = x;
      end
    endcase
    return res;
  endfunction

  logic           s1_valid;
  logic [VW-1:0]  s1_vec;
  logic [1:0]     s1_mode;
  logic           s2_ready;
  logic [VW-1:0]  act_vec;

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;

  always_comb begin
    act_vec = '0;
    for (int i = 0; i < int'(DIM); i++) begin
      act_vec[i*WIDTH +: WIDTH] = act_lane(s1_vec[i*WIDTH +: WIDTH], s1_mode);
    end
  end

  // Stage 1: capture the beat together with its mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_vec   <= '0;
      s1_mode  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_vec  <= in_vec;
        s1_mode <= in_mode;
      end
    end
  end

  // Stage 2: registered result, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_vec   <= '0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) out_vec <= act_vec;
    end
  end

`ifdef ACT_STREAM_ZERO_COUNT_EN
  localparam int unsigned CW = $clog2(DIM + 1);

  logic [CW-1:0] zero_lanes;
  logic [32:0]   cnt_sum;

  always_comb begin
    zero_lanes = '0;
    for (int i = 0; i < int'(DIM); i++) begin
      if (out_vec[i*WIDTH +: WIDTH] == '0) zero_lanes = zero_lanes + CW'(1);
    end
  end

  assign cnt_sum = {1'b0, zero_cnt} + 33'(zero_lanes);

  // Clear wins over a coincident transfer; the sum saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      zero_cnt <= '0;
    end else if (out_valid && out_ready) begin
      zero_cnt <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign zero_cnt       = '0;
`endif

endmodule

// File: tb/tb_act_stream.sv
// Self-checking bench for act_stream: queue-based reference model plus directed vectors.
// Honors ACT_STREAM_ZERO_COUNT_EN the same way as the design.
module tb_act_stream;

  localparam int unsigned DIM = 4;
  localparam int unsigned W   = 16;
  localparam int unsigned FR  = 8;
  localparam int unsigned LS  = 3;
  localparam int unsigned VW  = DIM * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [VW-1:0] in_vec;
  logic [1:0]    in_mode;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] out_vec;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   zero_cnt;
  logic          cnt_clr;

  int passed = 0;
  int total  = 0;

  act_stream #(.DIM(DIM), .WIDTH(W), .FRAC(FR), .LEAK_SHIFT(LS)) dut (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_mode(in_mode),
    .in_valid(in_valid), .in_ready(in_ready), .out_vec(out_vec),
    .out_valid(out_valid), .out_ready(out_ready), .zero_cnt(zero_cnt),
    .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: plain integer arithmetic per lane, floor division for leaky.
  function automatic logic [VW-1:0] model_beat(input logic [VW-1:0] v, input logic [1:0] m);
    logic [VW-1:0]        r;
    logic signed [W-1:0]  xs;
    int x, y, c;
    c = ((6 << FR) < ((1 << (W - 1)) - 1)) ? (6 << FR) : ((1 << (W - 1)) - 1);
    r = '0;
    for (int i = 0; i < int'(DIM); i++) begin
      xs = v[i*W +: W];
      x  = xs;
      case (m)
        2'd0: y = x;
        2'd1: y = (x < 0) ? 0 : x;
        2'd2: y = (x < 0) ? -((-x + (1 << LS) - 1) / (1 << LS)) : x;
        default: y = (x < 0) ? 0 : ((x > c) ? c : x);
      endcase
      r[i*W +: W] = W'(y);
    end
    return r;
  endfunction

  function automatic int zeros_in(input logic [VW-1:0] v);
    int n = 0;
    for (int i = 0; i < int'(DIM); i++) if (v[i*W +: W] == '0) n++;
    return n;
  endfunction

  function automatic logic [VW-1:0] pack4(input logic [15:0] a0, input logic [15:0] a1,
                                          input logic [15:0] a2, input logic [15:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // Scoreboard and per-cycle compare, sampled on the falling edge.
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] prev_vec;
  logic [VW-1:0] exp_beat;
  longint        zc_model = 0;
  bit            started = 0;
  bit            stall_prev = 0;
  int            out_seen = 0;

  always @(negedge clk) begin
    if (started) begin
      check("zero_cnt", 64'(zero_cnt), 64'(zc_model));
      if (stall_prev) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_vec", 64'(out_vec), 64'(prev_vec));
      end
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(out_vec), 64'hDEAD_0000_0000_DEAD);
        end else begin
          exp_beat = exp_q.pop_front();
          check("stream_out", 64'(out_vec), 64'(exp_beat));
          out_seen++;
        end
      end
    end
    if (rst) begin
      exp_q.delete();
      zc_model = 0;
    end else begin
`ifdef ACT_STREAM_ZERO_COUNT_EN
      if (cnt_clr) zc_model = 0;
      else if (out_valid && out_ready) begin
        zc_model = zc_model + zeros_in(out_vec);
        if (zc_model > 64'hFFFF_FFFF) zc_model = 64'hFFFF_FFFF;
      end
`endif
      if (in_valid && in_ready) exp_q.push_back(model_beat(in_vec, in_mode));
    end
    stall_prev = started && !rst && out_valid && !out_ready;
    prev_vec   = out_vec;
    if (rst) started = 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One beat into an empty pipeline; pins the exact 2-cycle latency and value.
  task automatic send_one(input string name, input logic [VW-1:0] v, input logic [1:0] m,
                          input logic [VW-1:0] exp, input bit clr);
    in_vec = v; in_mode = m; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "_early"}, 64'(out_valid), 64'd0);
    step();
    cnt_clr = clr;
    @(negedge clk);
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_vec"}, 64'(out_vec), 64'(exp));
    step();
    cnt_clr = 1'b0;
  endtask

  bit saw_block = 0;

  // Handshaked beat, waits (bounded) for acceptance.
  task automatic send_hs(input logic [VW-1:0] v, input logic [1:0] m);
    bit r;
    in_vec = v; in_mode = m; in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      r = in_ready;
      if (!r) saw_block = 1;
      step();
      if (r) begin
        in_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [15:0] l [4];
    rst = 1'b1; in_vec = '0; in_mode = '0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_vec", 64'(out_vec), 64'd0);
    check("rst_zero_cnt", 64'(zero_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    step();

    send_one("relu", pack4(16'h0100, 16'hFF00, 16'h0000, 16'h7FFF), 2'd1,
             pack4(16'h0100, 16'h0000, 16'h0000, 16'h7FFF), 1'b0);
    send_one("leaky", pack4(16'hFFF0, 16'hFFFF, 16'h8000, 16'h0040), 2'd2,
             pack4(16'hFFFE, 16'hFFFF, 16'hF000, 16'h0040), 1'b0);
    send_one("relu6", pack4(16'h0700, 16'h0600, 16'h05FF, 16'h8001), 2'd3,
             pack4(16'h0600, 16'h0600, 16'h05FF, 16'h0000), 1'b0);
    send_one("pass", pack4(16'h8000, 16'hFFFF, 16'h0000, 16'h1234), 2'd0,
             pack4(16'h8000, 16'hFFFF, 16'h0000, 16'h1234), 1'b0);
    send_one("relu_min", pack4(16'h8000, 16'h0001, 16'h7FFF, 16'hC000), 2'd1,
             pack4(16'h0000, 16'h0001, 16'h7FFF, 16'h0000), 1'b0);

    // Back-to-back burst with output stall in cycles 3..6.
    base = out_seen;
    saw_block = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          for (int j = 0; j < 4; j++)
            l[j] = 16'(i * 16'h0123 + j * 16'h4100 - 16'h0400);
          send_hs(pack4(l[0], l[1], l[2], l[3]), 2'(i % 4));
        end
      end
      begin
        repeat (3) step();
        out_ready = 1'b0;
        repeat (4) step();
        out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) step();
    repeat (2) step();
    check("burst_in_ready_fell", 64'(saw_block), 64'd1);
    check("burst_count", 64'(out_seen - base), 64'd10);
    check("burst_drained", 64'(exp_q.size()), 64'd0);

    // Zero counter: two counted beats, clear coincides with the third transfer.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    send_one("zc_a", pack4(16'h0100, 16'hFF00, 16'h8000, 16'h0200), 2'd1,
             pack4(16'h0100, 16'h0000, 16'h0000, 16'h0200), 1'b0);
    send_one("zc_b", pack4(16'hFFFF, 16'h0010, 16'h7FFF, 16'h8001), 2'd1,
             pack4(16'h0000, 16'h0010, 16'h7FFF, 16'h0000), 1'b0);
    @(negedge clk);
`ifdef ACT_STREAM_ZERO_COUNT_EN
    check("zc_after_two", 64'(zero_cnt), 64'd4);
`else
    check("zc_after_two", 64'(zero_cnt), 64'd0);
`endif
    step();
    send_one("zc_c", pack4(16'h0300, 16'hF000, 16'hFFFE, 16'h0001), 2'd1,
             pack4(16'h0300, 16'h0000, 16'h0000, 16'h0001), 1'b1);
    @(negedge clk);
    check("zc_after_clr", 64'(zero_cnt), 64'd0);
    step();

    // Mid-stream reset with two beats held in the pipeline.
    out_ready = 1'b0;
    in_vec = pack4(16'h0011, 16'h0022, 16'h0033, 16'h0044); in_mode = 2'd0; in_valid = 1'b1;
    step();
    in_vec = pack4(16'h0055, 16'h0066, 16'h0077, 16'h0088);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("flush_no_beat", 64'(out_valid), 64'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/act_stream.md
ACT_STREAM -- requirements
Module: act_stream

Interface
REQ-001 SHALL have parameter DIM, default 4, meaning the number of parallel lanes per beat.
REQ-002 SHALL have parameter WIDTH, default 16, meaning the signed two's-complement bits per lane.
REQ-003 SHALL have parameter FRAC, default 8, meaning the fractional bits per lane (Q8.8 at defaults).
REQ-004 SHALL have parameter LEAK_SHIFT, default 3, meaning the leaky-mode negative slope of 2^-LEAK_SHIFT.
REQ-005 SHALL have ports: clk  in  1  clock; all logic on the rising edge.
REQ-006 SHALL have ports: rst  in  1  reset; synchronous, active-high.
REQ-007 SHALL have ports: in_vec  in  DIM*WIDTH  input lanes, lane i = [i*WIDTH +: WIDTH].
REQ-008 SHALL have ports: in_mode  in  2  activation mode, travelling with the beat.
REQ-009 SHALL have ports: in_valid  in  1 and in_ready  out  1  input handshake.
REQ-010 SHALL have ports: out_vec  out  DIM*WIDTH  result lanes, same packing as in_vec.
REQ-011 SHALL have ports: out_valid  out  1 and out_ready  in  1  output handshake.
REQ-012 SHALL have ports: zero_cnt  out  32  count of zero-valued output lanes.
REQ-013 SHALL have ports: cnt_clr  in  1  synchronous clear of zero_cnt.

Function
REQ-014 SHALL transfer a beat when valid && ready; no beat SHALL be dropped or duplicated.
REQ-015 SHALL use a two-stage elastic pipeline.
  - S1 registers the input and the mode.
  - S2 registers the computed result.
  - Latency is 2 cycles from input acceptance to out_valid under no backpressure.
REQ-016 SHALL advance each stage when it is empty or its downstream stage advances in the same cycle.
  - in_ready = !s1_valid || s1_advance, with no combinational path from in_valid.
REQ-017 SHALL sustain 1 beat/cycle throughput when out_ready is held high.
REQ-018 SHALL hold out_vec and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL select the per-lane result by mode:
  - 0 = pass-through.
  - 1 = ReLU: the result is 0 if the sign bit is set, else x.
  - 2 = leaky: x if x >= 0, else x >>> LEAK_SHIFT (arithmetic shift, rounding toward -inf).
  - 3 = ReLU6: clamp x to [0, C], where C = min(6 << FRAC, 2^(WIDTH-1)-1).
REQ-020 SHALL compute all lanes independently with no cross-lane dependence; the output width SHALL equal WIDTH, with no growth.
REQ-021 SHALL apply the mode captured with each beat, so a mode change between consecutive beats takes effect exactly at the beat boundary.
REQ-022 SHALL treat the most negative value (0x8000 at WIDTH 16) as negative in every mode; in mode 2 it SHALL map to 0x8000 >>> LEAK_SHIFT.
REQ-023 SHALL update the zero counter as follows:
  - On each output transfer, zero_cnt increases by the number of lanes equal to 0.
  - zero_cnt saturates at 2^32-1.
REQ-024 SHALL apply cnt_clr with priority over counting: if cnt_clr coincides with a transfer, zero_cnt becomes 0 that cycle and the beat is not counted.

Reset
REQ-025 SHALL, while rst is high, clear all stage valid flags and drive out_valid=0, out_vec=0, zero_cnt=0.
REQ-026 SHALL drive in_ready=1 in the first cycle after rst deasserts.
REQ-027 SHALL discard any in-flight beats when rst is asserted mid-stream; no such beat SHALL appear after reset.

Configuration
REQ-028 SHALL compile the zero counter only when macro ACT_STREAM_ZERO_COUNT_EN is defined.
  - With the macro: REQ-023 and REQ-024 apply.
  - Without the macro: zero_cnt is constant 0, cnt_clr is ignored, and no counter logic is present.
  - Ports are identical in both builds.

Verification
REQ-029 SHALL cover: DIM=4, mode 1, in lanes {0x0100, 0xFF00, 0x0000, 0x7FFF}, out_ready=1 -> out {0x0100, 0x0000, 0x0000, 0x7FFF} exactly 2 cycles later.
REQ-030 SHALL cover: mode 2, lanes {0xFFF0, 0xFFFF, 0x8000, 0x0040} -> {0xFFFE, 0xFFFF, 0xF000, 0x0040}.
REQ-031 SHALL cover: mode 3, lanes {0x0700, 0x0600, 0x05FF, 0x8001} -> {0x0600, 0x0600, 0x05FF, 0x0000}.
REQ-032 SHALL cover: 10 back-to-back beats, out_ready low for cycles 3-6 -> in_ready falls once both stages are full, and all 10 outputs arrive in order with no loss or duplication.
REQ-033 SHALL cover: with the macro defined, 3 ReLU beats each containing 2 negative lanes, cnt_clr pulsed together with the 3rd output transfer -> zero_cnt reads 4 after 2 beats, then 0; without the macro, zero_cnt stays 0.
REQ-034 SHALL cover: rst asserted for 1 cycle with 2 beats in flight -> out_valid=0 the next cycle, in_ready=1, and neither beat ever emerges.
